// File: rtl/clock_tree_generator.sv
// Divide-by-2^n clock tree: an 8-bit up-counter whose bits are the divided clocks.
// Dropping start lets the counter run to its wrap, so every output finishes its period.
module clock_tree_generator (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start,
    output logic clk_0_out,
    output logic clk_1_out,
    output logic clk_2_out,
    output logic clk_3_out,
    output logic clk_4_out,
    output logic clk_5_out,
    output logic clk_6_out,
    output logic clk_7_out
);

    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;

    // Next count: keep running while requested or mid-sequence, otherwise park at zero.
    always_comb begin
        w_cnt_nxt = 8'd0;
        if (start || (r_cnt != 8'd0)) begin
            w_cnt_nxt = r_cnt + 8'd1;
        end else begin
            w_cnt_nxt = 8'd0;
        end
    end

    // Counter register with synchronous reset taking priority over start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Outputs are the flop bits themselves, so they cannot glitch.
    assign clk_0_out = r_cnt[0];
    assign clk_1_out = r_cnt[1];
    assign clk_2_out = r_cnt[2];
    assign clk_3_out = r_cnt[3];
    assign clk_4_out = r_cnt[4];
    assign clk_5_out = r_cnt[5];
    assign clk_6_out = r_cnt[6];
    assign clk_7_out = r_cnt[7];

endmodule

// File: tb/tb_clock_tree_generator.sv
// Self-checking bench for clock_tree_generator: vector table, corner sequences,
// period/duty measurement and randomized start/reset against a phase-based model.
module tb_clock_tree_generator;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic start = 1'b1;
    logic clk_0_out, clk_1_out, clk_2_out, clk_3_out;
    logic clk_4_out, clk_5_out, clk_6_out, clk_7_out;
    logic [7:0] outs;

    int n_cmp = 0;
    int n_bad = 0;
    int m_phase = 0;

    typedef struct {
        logic       rst;
        logic       st;
        logic [7:0] exp;
    } vec_t;

    clock_tree_generator dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start     (start),
        .clk_0_out (clk_0_out),
        .clk_1_out (clk_1_out),
        .clk_2_out (clk_2_out),
        .clk_3_out (clk_3_out),
        .clk_4_out (clk_4_out),
        .clk_5_out (clk_5_out),
        .clk_6_out (clk_6_out),
        .clk_7_out (clk_7_out)
    );

    assign outs = {clk_7_out, clk_6_out, clk_5_out, clk_4_out,
                   clk_3_out, clk_2_out, clk_1_out, clk_0_out};

    // 10 ns system clock.
    always #5 clk_i = ~clk_i;

    // Output k is high during the second half of each 2^(k+1)-cycle period.
    function automatic logic [7:0] model_outs(input int p);
        logic [7:0] v;
        v = 8'h00;
        for (int k = 0; k < 8; k++) begin
            v[k] = ((p % (1 << (k + 1))) >= (1 << k));
        end
        return v;
    endfunction

    task automatic chk_outs(input string name, input logic [7:0] exp);
        n_cmp++;
        if (outs !== exp) begin
            n_bad++;
            $display("FAIL %s: outputs %b, expected %b", name, outs, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Drive inputs, take one rising edge, advance the model, settle before sampling.
    task automatic step(input logic r, input logic s);
        rst_i = r;
        start = s;
        @(posedge clk_i);
        if (r) begin
            m_phase = 0;
        end else if (s || m_phase != 0) begin
            m_phase = (m_phase + 1) % 256;
        end else begin
            m_phase = 0;
        end
        #1;
    endtask

    initial begin
        vec_t vecs[13];
        logic [7:0] prev;
        int last_rise[8];
        int edges;

        vecs[0]  = '{1'b1, 1'b1, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 8'h00};
        vecs[2]  = '{1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 1'b1, 8'h01};
        vecs[6]  = '{1'b0, 1'b0, 8'h02};
        vecs[7]  = '{1'b0, 1'b0, 8'h03};
        vecs[8]  = '{1'b0, 1'b1, 8'h04};
        vecs[9]  = '{1'b0, 1'b0, 8'h05};
        vecs[10] = '{1'b1, 1'b1, 8'h00};
        vecs[11] = '{1'b0, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 1'b1, 8'h01};
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].rst, vecs[i].st);
            chk_outs($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Idle after reset with start low stays quiet.
        step(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0);
            if (i == 0 || i == 19) chk_outs("idle_hold", 8'h00);
        end

        // Continuous run from idle: first rise at 2^k, rise spacing 2^(k+1), high time 2^k.
        prev = 8'h00;
        for (int k = 0; k < 8; k++) last_rise[k] = -1;
        for (int j = 1; j <= 600; j++) begin
            step(1'b0, 1'b1);
            if (j == 1) chk_outs("start_latency", 8'h01);
            for (int k = 0; k < 8; k++) begin
                if (!prev[k] && outs[k]) begin
                    if (last_rise[k] < 0) chk_int($sformatf("first_rise%0d", k), j, 1 << k);
                    else chk_int($sformatf("period%0d", k), j - last_rise[k], 1 << (k + 1));
                    last_rise[k] = j;
                end
                if (prev[k] && !outs[k]) begin
                    chk_int($sformatf("duty%0d", k), j - last_rise[k], 1 << k);
                end
            end
            prev = outs;
        end

        // Graceful stop at cnt=10: 246 more edges, all outputs fall together.
        step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        chk_outs("stop_at10", 8'h0a);
        edges = 0;
        prev = outs;
        while (outs != 8'h00 && edges < 300) begin
            prev = outs;
            step(1'b0, 1'b0);
            edges++;
        end
        chk_int("drain_edges", edges, 246);
        n_cmp++;
        if (prev !== 8'hff) begin
            n_bad++;
            $display("FAIL drain_prev: before wrap %b, expected 11111111", prev);
        end
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        chk_outs("drain_idle", 8'h00);

        // Restart during drain keeps the count contiguous 1..30.
        step(1'b1, 1'b0);
        for (int e = 1; e <= 30; e++) begin
            step(1'b0, (e <= 10 || e > 20) ? 1'b1 : 1'b0);
            chk_outs($sformatf("restart%0d", e), 8'(e));
        end

        // Reset mid-run at cnt=77 overrides start, then counting restarts at 1.
        step(1'b1, 1'b0);
        for (int i = 0; i < 77; i++) step(1'b0, 1'b1);
        chk_outs("pre_reset77", 8'd77);
        step(1'b1, 1'b1);
        chk_outs("reset_mid", 8'h00);
        step(1'b0, 1'b1);
        chk_outs("after_reset", 8'h01);

        // Start dropped at 255: wrap straight to idle.
        step(1'b1, 1'b0);
        for (int i = 0; i < 255; i++) step(1'b0, 1'b1);
        chk_outs("at255", 8'hff);
        step(1'b0, 1'b0);
        chk_outs("wrap_idle", 8'h00);
        step(1'b0, 1'b0);
        chk_outs("wrap_idle2", 8'h00);

        // Randomized start/reset against the phase model.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(199) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(19) < 2) ? 1'b1 : 1'b0);
            chk_outs("random", model_outs(m_phase));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
